// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: qualifies MEM-stage traps and ERET, commits CP0 state, flushes, redirects fetch.
// Latency: detect T, CP0 commit pulse T+1, redirect_valid from T+2, back in IDLE at T+3 with ready high.
// Backpressure: redirect held stable (flush asserted) until redirect_ready; MEM inputs ignored until then.
module exc_ctrl #(
   parameter logic [31:0] VECTOR = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic        mem_adel_if,
   input  logic        mem_ri,
   input  logic        mem_ov,
   input  logic        mem_sys,
   input  logic        mem_bp,
   input  logic        mem_adel_d,
   input  logic        mem_ades,
   input  logic        mem_eret,
   input  logic [31:0] status_in,
   input  logic [31:0] cause_in,
   input  logic [31:0] epc_in,
   input  logic        mtc0_we,
   input  logic [4:0]  mtc0_reg,
   input  logic [31:0] mtc0_data,
   output logic        cp0_exl,
   output logic        cp0_exc_we,
   output logic        cp0_bd,
   output logic [4:0]  cp0_exccode,
   output logic [31:0] cp0_epc,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
);

   typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

   localparam logic [4:0] CODE_INT  = 5'd0;
   localparam logic [4:0] CODE_ADEL = 5'd4;
   localparam logic [4:0] CODE_ADES = 5'd5;
   localparam logic [4:0] CODE_SYS  = 5'd8;
   localparam logic [4:0] CODE_BP   = 5'd9;
   localparam logic [4:0] CODE_RI   = 5'd10;
   localparam logic [4:0] CODE_OV   = 5'd12;
   localparam logic [4:0] REG_STATUS = 5'd12;

   state_t      state;
   logic        kind_trap;   // 1: pending event is a trap, 0: ERET
   logic        int_pending;
   logic        any_flag;
   logic        trap;
   logic        eret_go;
   logic [4:0]  trap_code;
   logic [31:0] trap_epc;

   // Bits of the CP0 words this block does not look at.
   logic unused_bits;
   assign unused_bits = ^{status_in[31:16], status_in[7:2], cause_in[31:16], cause_in[7:0],
                          mtc0_data[31:2], mtc0_data[0]};

   assign int_pending = status_in[0] & ~status_in[1] & (|(status_in[15:8] & cause_in[15:8]));
   assign any_flag    = mem_adel_if | mem_ri | mem_ov | mem_sys | mem_bp | mem_adel_d | mem_ades;
   assign trap        = mem_valid & (int_pending | any_flag);
   assign eret_go     = mem_valid & mem_eret & ~trap;
   // EPC points at the branch when the faulting instruction is in its delay slot; wraps modulo 2^32.
   assign trap_epc    = mem_bd ? (mem_pc - 32'd4) : mem_pc;

   // Fixed-priority ExcCode selection; interrupts win over every synchronous flag.
   always_comb begin
      trap_code = CODE_INT;
      if (int_pending)      trap_code = CODE_INT;
      else if (mem_adel_if) trap_code = CODE_ADEL;
      else if (mem_ri)      trap_code = CODE_RI;
      else if (mem_ov)      trap_code = CODE_OV;
      else if (mem_sys)     trap_code = CODE_SYS;
      else if (mem_bp)      trap_code = CODE_BP;
      else if (mem_adel_d)  trap_code = CODE_ADEL;
      else if (mem_ades)    trap_code = CODE_ADES;
   end

   // Control FSM with all outputs registered; CP0 cause fields hold their last committed trap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         kind_trap      <= 1'b0;
         cp0_exl        <= 1'b0;
         cp0_exc_we     <= 1'b0;
         cp0_bd         <= 1'b0;
         cp0_exccode    <= 5'd0;
         cp0_epc        <= 32'd0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (mtc0_we && (mtc0_reg == REG_STATUS)) begin
                  cp0_exl <= mtc0_data[1];
               end
               if (trap) begin
                  kind_trap   <= 1'b1;
                  cp0_exccode <= trap_code;
                  cp0_bd      <= mem_bd;
                  cp0_epc     <= trap_epc;
                  cp0_exc_we  <= 1'b1;
                  redirect_pc <= VECTOR;
                  flush       <= 1'b1;
                  state       <= COMMIT;
               end else if (eret_go) begin
                  kind_trap   <= 1'b0;
                  redirect_pc <= epc_in;
                  flush       <= 1'b1;
                  state       <= COMMIT;
               end
            end
            COMMIT: begin
               cp0_exc_we     <= 1'b0;
               cp0_exl        <= kind_trap;
               redirect_valid <= 1'b1;
               state          <= REDIRECT;
            end
            REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid <= 1'b0;
                  flush          <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller that drives the coprocessor-0 register block from the pipeline side. It samples exception flags and the PC of the instruction in the MEM stage and qualifies pending hardware interrupts against STATUS/CAUSE. It then commits EXL/BD/ExcCode/EPC into CP0, flushes the pipeline and hands a redirect PC to fetch. It also executes ERET: clears EXL and redirects to EPC.

## Interface
- `VECTOR`, 32'h8000_0180, exception handler entry PC
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_valid`  in  1  MEM-stage slot holds a real instruction
- `mem_pc`  in  32  PC of the MEM-stage instruction
- `mem_bd`  in  1  MEM instruction sits in a branch delay slot
- `mem_adel_if`, `mem_ri`, `mem_ov`, `mem_sys`, `mem_bp`, `mem_adel_d`, `mem_ades`  in  1 each  exception flags
- `mem_eret`  in  1  MEM instruction is ERET
- `status_in`  in  32  CP0 STATUS (bit0 IE, bit1 EXL, bits15:8 IM)
- `cause_in`  in  32  CP0 CAUSE (bits15:8 IP)
- `epc_in`  in  32  CP0 EPC
- `mtc0_we`, `mtc0_reg[4:0]`, `mtc0_data[31:0]`  in  software CP0 write, for EXL tracking
- `cp0_exl`  out  1  level driven into CP0 STATUS_EXL
- `cp0_exc_we`  out  1  one-cycle pulse: CP0 latches BD/ExcCode/EPC
- `cp0_bd`  out  1  BD value for CAUSE
- `cp0_exccode`  out  5  ExcCode for CAUSE
- `cp0_epc`  out  32  EPC value
- `flush`  out  1  kill IF..MEM contents
- `redirect_valid`  out  1  redirect PC offered to fetch
- `redirect_pc`  out  32  target PC
- `redirect_ready`  in  1  fetch accepts the redirect

## Operation
- States: IDLE, COMMIT, REDIRECT. Reset enters IDLE.
- Interrupt pending: `status_in[0] & ~status_in[1] & |(status_in[15:8] & cause_in[15:8])`.
- Trap in IDLE: `mem_valid & (int_pending | any flag)`.
- Fixed code priority, highest first: Int 0, AdEL-fetch 4, RI 10, Ov 12, Sys 8, Bp 9, AdEL-data 4, AdES 5.
- On a trap, the block registers the code, BD, and EPC. EPC = `mem_pc - 4` if `mem_bd`, else `mem_pc`. Then IDLE→COMMIT.
- ERET in IDLE with no trap: register `epc_in` as target, kind=ERET, IDLE→COMMIT. Trap beats ERET in the same cycle.
- COMMIT (exactly 1 cycle):
  - On a trap: `cp0_exc_we`=1 and `cp0_exl`←1 at end of cycle.
  - On ERET: `cp0_exc_we`=0 and `cp0_exl`←0.
  - Then →REDIRECT.
- REDIRECT:
  - `redirect_valid`=1. `redirect_pc` = VECTOR for a trap, or the registered EPC for ERET.
  - Held stable until `redirect_ready`, then →IDLE.
- `flush`=1 in COMMIT and REDIRECT.
- While not IDLE, all MEM inputs are ignored and no new trap or ERET is accepted.
- EXL tracking: in IDLE, `mtc0_we & mtc0_reg==12` loads `cp0_exl`←`mtc0_data[1]`. A COMMIT update overrides an mtc0 write in the same cycle.
- Subtraction is modulo 2^32: `mem_pc`=0 with BD gives EPC 32'hFFFF_FFFC.

## Timing
- Reset values: state IDLE, `cp0_exl`=0, `cp0_exc_we`=0, `cp0_bd`=0, `cp0_exccode`=0, `cp0_epc`=0, `flush`=0, `redirect_valid`=0, `redirect_pc`=0.
- All outputs are registered or decoded from state and registers only. There is no combinational path from MEM inputs to outputs.
- Latency:
  - Detect in cycle T, COMMIT at T+1, `redirect_valid` from T+2.
  - With `redirect_ready` held high, the FSM is back in IDLE at T+3 and can accept a new event in that cycle.
- `cp0_bd`, `cp0_exccode`, `cp0_epc` hold their last committed values between events.
- Reset asserted mid-operation: immediate return to IDLE with reset values. A half-issued redirect is dropped.
- `redirect_ready` is ignored outside REDIRECT.

## Test plan
- Syscall: `mem_sys`=1, `mem_pc`=32'h0040_0010, `mem_bd`=0.
  - Expect at T+1 `cp0_exc_we`=1, code 8, EPC 32'h0040_0010, `cp0_exl`=1 at T+2.
  - Expect `redirect_pc`=32'h8000_0180, `flush`=1 at T+1..T+2.
- Delay-slot overflow: `mem_ov`=1, `mem_bd`=1, `mem_pc`=32'h0040_0024. Expect code 12, BD=1, EPC 32'h0040_0020.
- Priority: `mem_ri`, `mem_ov`, `mem_ades` all set, plus a pending IP2 with IM2=1, IE=1, EXL=0. Expect code 0. Repeat with IE=0: expect code 10.
- ERET: `epc_in`=32'h0040_0100, `mem_eret`=1. Expect no `cp0_exc_we`, `cp0_exl`→0, `redirect_pc`=32'h0040_0100.
- Backpressure: hold `redirect_ready`=0 for 5 cycles, and pulse `mem_sys` during that time. Expect `redirect_valid`/`redirect_pc` stable, `flush`=1 throughout, the second syscall ignored, and IDLE one cycle after ready.
- Async reset in REDIRECT: drop `rst` mid-cycle. Expect all outputs 0 immediately; after release, the FSM is IDLE with EXL=0.
